dt_res_scan: RTL and testbench

DT_RES_SCAN -- requirements
Module: dt_res_scan

---
 rtl/dt_res_scan.sv | 138 +++++++++++++
 tb/tb_dt_res_scan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dt_res_scan.sv
// Distance-map result scanner: streams all 16384 pixels of the result RAM and reports
// the maximum value, its first address and the foreground pixel count. Optional
// distance histogram enabled by defining DT_SCAN_HIST_EN.
module dt_res_scan (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        busy,
  output logic        done,
  output logic [7:0]  max_val,
  output logic [13:0] max_addr,
  output logic [14:0] fg_count
`ifdef DT_SCAN_HIST_EN
  ,
  input  logic [2:0]  hist_sel,
  output logic [14:0] hist_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [13:0] LAST_ADDR = 14'h3FFF;

  state_e      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic        smp_vld_q, smp_vld_d;
  logic [13:0] smp_addr_q, smp_addr_d;
  logic [7:0]  max_val_q, max_val_d;
  logic [13:0] max_addr_q, max_addr_d;
  logic [14:0] fg_q, fg_d;
  logic        clr;

`ifdef DT_SCAN_HIST_EN
  logic [7:0][14:0] bin_q, bin_d;
  logic [2:0]       bin_idx;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    clr        = 1'b0;
    // res_di lags the issued address by one cycle, so the address rides along one stage
    smp_vld_d  = (state_q == READ);
    smp_addr_d = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = 14'd0;
          clr     = 1'b1;
        end
      end
      READ: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          addr_d  = 14'd0;
        end else begin
          addr_d = addr_q + 14'd1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    max_val_d  = max_val_q;
    max_addr_d = max_addr_q;
    fg_d       = fg_q;
    if (clr) begin
      max_val_d  = 8'd0;
      max_addr_d = 14'd0;
      fg_d       = 15'd0;
    end else if (smp_vld_q) begin
      if (res_di != 8'd0) fg_d = fg_q + 15'd1;
      // strict compare keeps the lowest address on ties
      if (res_di > max_val_q) begin
        max_val_d  = res_di;
        max_addr_d = smp_addr_q;
      end
    end
  end

`ifdef DT_SCAN_HIST_EN
  assign bin_idx = (res_di >= 8'd7) ? 3'd7 : res_di[2:0];

  always_comb begin
    bin_d = bin_q;
    if (clr) begin
      bin_d = '0;
    end else if (smp_vld_q) begin
      bin_d[bin_idx] = bin_q[bin_idx] + 15'd1;
    end
  end

  assign hist_cnt = bin_q[hist_sel];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 14'd0;
      smp_vld_q  <= 1'b0;
      smp_addr_q <= 14'd0;
      max_val_q  <= 8'd0;
      max_addr_q <= 14'd0;
      fg_q       <= 15'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      smp_vld_q  <= smp_vld_d;
      smp_addr_q <= smp_addr_d;
      max_val_q  <= max_val_d;
      max_addr_q <= max_addr_d;
      fg_q       <= fg_d;
    end
  end

`ifdef DT_SCAN_HIST_EN
  always_ff @(posedge clk) begin
    if (reset) bin_q <= '0;
    else       bin_q <= bin_d;
  end
`endif

  assign res_rd   = (state_q == READ);
  assign res_addr = addr_q;
  assign busy     = (state_q == READ) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign max_val  = max_val_q;
  assign max_addr = max_addr_q;
  assign fg_count = fg_q;

endmodule

// File: tb/tb_dt_res_scan.sv
// Bench for dt_res_scan: table of map patterns with expected results, a reference model
// feeding a scoreboard queue, plus reset-abort and held-start sequences.
module tb_dt_res_scan;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        busy, done;
  logic [7:0]  max_val;
  logic [13:0] max_addr;
  logic [14:0] fg_count;
`ifdef DT_SCAN_HIST_EN
  logic [2:0]  hist_sel;
  logic [14:0] hist_cnt;
`endif

  dt_res_scan dut (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .busy(busy), .done(done),
    .max_val(max_val), .max_addr(max_addr), .fg_count(fg_count)
`ifdef DT_SCAN_HIST_EN
    , .hist_sel(hist_sel), .hist_cnt(hist_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int max_v;
    int max_a;
    int fg;
  } exp_t;

  typedef struct {
    int   kind;
    exp_t e;
  } vec_t;

  logic [7:0] mem [16384];
  exp_t       sb[$];
  int         n_chk = 0, n_err = 0;
  bit         mon_en = 0, mon_bad = 0;
  int         mon_addr = 0, mon_rd = 0, done_cnt = 0;

  // RAM model: data valid one cycle after the read strobe
  always @(posedge clk) res_di <= res_rd ? mem[res_addr] : 8'h00;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_en) begin
      if (res_rd) begin
        if (int'(res_addr) != mon_addr) mon_bad = 1;
        mon_addr++;
        mon_rd++;
      end else if (res_addr != 14'd0) begin
        mon_bad = 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < 16384; i++) begin
      case (kind)
        1:       mem[i] = (i == 5000 || i == 9000) ? 8'd3 : 8'd0;
        2:       mem[i] = (i == 16383) ? 8'd9 : 8'd1;
        3:       mem[i] = (i == 77) ? 8'd2 : (i == 12000) ? 8'd200 : 8'd0;
        default: mem[i] = 8'd0;
      endcase
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e.max_v = 0; e.max_a = 0; e.fg = 0;
    for (int i = 0; i < 16384; i++) begin
      if (mem[i] != 0) e.fg++;
      if (int'(mem[i]) > e.max_v) begin
        e.max_v = int'(mem[i]);
        e.max_a = i;
      end
    end
    return e;
  endfunction

  task automatic chk_res(input string tag, input exp_t e);
    chk({tag, "_max_val"},  int'(max_val),  e.max_v);
    chk({tag, "_max_addr"}, int'(max_addr), e.max_a);
    chk({tag, "_fg_count"}, int'(fg_count), e.fg);
  endtask

  // One full scan; start is held for the whole scan when hold=1
  task automatic run_scan(input bit hold, input exp_t tbl);
    exp_t e;
    int   n, d0;
    sb.push_back(model());
    mon_addr = 0; mon_rd = 0; mon_bad = 0; mon_en = 1;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    n = 1;
    chk("first_busy", int'(busy), 1);
    chk("first_rd",   int'(res_rd), 1);
    chk("first_addr", int'(res_addr), 0);
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    mon_en = 0;
    chk("latency",   n, 16386);
    chk("rd_count",  mon_rd, 16384);
    chk("addr_seq",  int'(mon_bad), 0);
    chk("done_busy", int'(busy), 0);
    e = sb.pop_front();
    chk_res("sb", e);
    chk_res("tbl", tbl);
    repeat (5) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("idle_busy", int'(busy), 0);
    chk_res("hold", e);
  endtask

  initial begin
    vec_t tbl[3];
    int   n;
    exp_t h;
    tbl[0] = '{kind: 0, e: '{max_v: 0, max_a: 0,     fg: 0}};
    tbl[1] = '{kind: 1, e: '{max_v: 3, max_a: 5000,  fg: 2}};
    tbl[2] = '{kind: 2, e: '{max_v: 9, max_a: 16383, fg: 16384}};
`ifdef DT_SCAN_HIST_EN
    hist_sel = 3'd0;
`endif
    reset = 1'b1; start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd",   int'(res_rd), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(res_addr), 0);
    chk_res("rst", '{max_v: 0, max_a: 0, fg: 0});
    reset = 1'b0;

    // Abort a scan at cycle 800; reset also wins over a simultaneous start
    fill(2);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    while (n < 800) begin @(negedge clk); n++; end
    chk("pre_rst_fg", int'(fg_count), 798);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rd",   int'(res_rd), 0);
    chk("abort_addr", int'(res_addr), 0);
    chk_res("abort", '{max_v: 0, max_a: 0, fg: 0});
    @(negedge clk);
    chk("rst_prio_busy", int'(busy), 0);
    reset = 1'b0; start = 1'b0;
    n = done_cnt;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - n, 0);
    chk("abort_idle", int'(busy), 0);

    for (int i = 0; i < 3; i++) begin
      fill(tbl[i].kind);
      run_scan(1'b0, tbl[i].e);
    end

    fill(3);
    h = '{max_v: 200, max_a: 12000, fg: 2};
    run_scan(1'b1, h);
`ifdef DT_SCAN_HIST_EN
    for (int k = 0; k < 8; k++) begin
      hist_sel = 3'(k);
      #1;
      chk($sformatf("hist_bin%0d", k), int'(hist_cnt),
          (k == 0) ? 16382 : (k == 2 || k == 7) ? 1 : 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
